// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states, oversample rate
// and small combinational helpers used by the RX (and later TX) datapaths.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } uart_parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

  localparam int UART_OS_RATE = 16;

  // A parity bit is present only for the even and odd modes; 2'b11 behaves as none.
  function automatic logic uart_parity_enabled(input logic [1:0] mode);
    logic en;
    case (mode)
      PAR_EVEN: en = 1'b1;
      PAR_ODD:  en = 1'b1;
      default:  en = 1'b0;
    endcase
    return en;
  endfunction

  // Expected parity bit for a byte: even mode is the XOR of the data, odd its inverse.
  function automatic logic uart_parity_expected(input logic [7:0] data,
                                                input logic [1:0] mode);
    logic p;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~(^data);
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

  // Two-out-of-three vote over the mid-bit samples.
  function automatic logic uart_majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a down-counter reloaded with the divisor that
// emits a one-cycle registered tick each time it reaches zero. A divisor of
// zero yields a tick every cycle. restart realigns the tick phase.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic                 tick_r;

  // Divisor countdown with reload and tick strobe.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cnt_r  <= {DIV_WIDTH{1'b0}};
      tick_r <= 1'b0;
    end else if (restart) begin
      cnt_r  <= div;
      tick_r <= 1'b0;
    end else if (cnt_r == {DIV_WIDTH{1'b0}}) begin
      cnt_r  <= div;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive front end: synchronises the serial pin, recovers 8-bit frames
// with 16x oversampling and 3-sample majority voting, checks parity and stop
// bit, and holds each byte with its error flags on a valid/ready interface.
// The receiver never waits for the consumer; a byte completing while the
// previous one is still unaccepted is dropped and flagged with rx_overrun.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OS_RATE   = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 uart_rx,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);

  // Line conditioning
  logic       sync1_r, sync2_r, prev_r;
  logic [1:0] settle_r;
  logic       armed_r;
  logic       fall_s;

  // Frame recovery
  uart_rx_state_t       state_r;
  logic [3:0]           os_cnt_r;
  logic [2:0]           bit_idx_r;
  logic [1:0]           samp_r;
  logic [7:0]           shift_r;
  logic                 par_bit_r;
  logic                 par_err_r;
  logic [DIV_WIDTH-1:0] div_r;
  logic [1:0]           par_mode_r;
  logic                 busy_r;

  logic                 tick_s;
  logic                 restart_s;
  logic [DIV_WIDTH-1:0] div_sel_s;
  logic [3:0]           os_next_s;
  logic                 decide_s;
  logic                 wrap_s;
  logic                 maj_s;
  logic                 par_en_s;
  logic                 complete_s;
  logic                 frame_err_s;
  logic                 break_s;

  // Holding register
  logic [7:0] data_r;
  logic       valid_r;
  logic       frame_err_r;
  logic       parity_err_r;
  logic       break_r;
  logic       overrun_r;

  // Two-flop synchroniser, edge-detect copy, and arming: edges are accepted
  // only after the synchronised line has been seen high following reset, so a
  // line already low at reset release never looks like a start bit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      prev_r   <= 1'b1;
      settle_r <= 2'd0;
      armed_r  <= 1'b0;
    end else begin
      sync1_r <= uart_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (settle_r != 2'd2) begin
        settle_r <= settle_r + 2'd1;
      end
      if ((settle_r == 2'd2) && sync2_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  assign fall_s = armed_r & prev_r & ~sync2_r;

  // The divisor follows the live input while idle and the latched copy mid-frame.
  assign restart_s = fall_s && (state_r == IDLE);
  assign div_sel_s = (state_r == IDLE) ? baud_div : div_r;

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .restart       (restart_s),
    .div           (div_sel_s),
    .tick          (tick_s)
  );

  // Sample points are the ticks taking os_cnt to 7, 8 and 9; the vote is
  // resolved on the tick reaching 9 and the bit slot ends on the 15->0 wrap.
  assign os_next_s   = os_cnt_r + 4'd1;
  assign decide_s    = tick_s && (os_next_s == 4'd9);
  assign wrap_s      = tick_s && (os_cnt_r == OS_LAST);
  assign maj_s       = uart_majority3(samp_r[0], samp_r[1], sync2_r);
  assign par_en_s    = uart_parity_enabled(par_mode_r);
  assign complete_s  = (state_r == STOP) && decide_s;
  assign frame_err_s = ~maj_s;
  assign break_s     = ~maj_s && (shift_r == 8'h00) && !(par_en_s && par_bit_r);

  // Receive FSM: start validation, LSB-first shift, parity check, stop decision.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r    <= IDLE;
      os_cnt_r   <= 4'd0;
      bit_idx_r  <= 3'd0;
      samp_r     <= 2'b00;
      shift_r    <= 8'h00;
      par_bit_r  <= 1'b0;
      par_err_r  <= 1'b0;
      div_r      <= {DIV_WIDTH{1'b0}};
      par_mode_r <= 2'b00;
      busy_r     <= 1'b0;
    end else begin
      if ((state_r != IDLE) && tick_s) begin
        os_cnt_r <= os_next_s;
        if (os_next_s == 4'd7) begin
          samp_r[0] <= sync2_r;
        end
        if (os_next_s == 4'd8) begin
          samp_r[1] <= sync2_r;
        end
      end
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_r    <= START;
            os_cnt_r   <= 4'd0;
            bit_idx_r  <= 3'd0;
            samp_r     <= 2'b00;
            shift_r    <= 8'h00;
            par_bit_r  <= 1'b0;
            par_err_r  <= 1'b0;
            div_r      <= baud_div;
            par_mode_r <= parity_mode;
            busy_r     <= 1'b1;
          end
        end
        START: begin
          if (decide_s && maj_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (wrap_s) begin
            state_r <= DATA;
          end
        end
        DATA: begin
          if (decide_s) begin
            shift_r <= {maj_s, shift_r[7:1]};
          end
          if (wrap_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= par_en_s ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (decide_s) begin
            par_bit_r <= maj_s;
            par_err_r <= maj_s ^ uart_parity_expected(shift_r, par_mode_r);
          end
          if (wrap_s) begin
            state_r <= STOP;
          end
        end
        STOP: begin
          if (decide_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      data_r       <= 8'h00;
      valid_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      break_r      <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (complete_s) begin
        if (valid_r && !rx_ready) begin
          overrun_r <= 1'b1;
        end else begin
          data_r       <= shift_r;
          valid_r      <= 1'b1;
          frame_err_r  <= frame_err_s;
          parity_err_r <= par_err_r;
          break_r      <= break_s;
        end
      end else if (valid_r && rx_ready) begin
        valid_r      <= 1'b0;
        frame_err_r  <= 1'b0;
        parity_err_r <= 1'b0;
        break_r      <= 1'b0;
      end
    end
  end

  assign rx_data       = data_r;
  assign rx_valid      = valid_r;
  assign rx_frame_err  = frame_err_r;
  assign rx_parity_err = parity_err_r;
  assign rx_break      = break_r;
  assign rx_overrun    = overrun_r;
  assign rx_busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a table of frames with hand-computed
// results, plus sequences for false start, majority vote, overrun,
// same-cycle handshake and mid-frame reset.
module tb_uart_rx_core;
  import uart_pkg::*;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        uart_rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_frame_err;
  logic        rx_parity_err;
  logic        rx_break;
  logic        rx_overrun;
  logic        rx_busy;

  int checks = 0;
  int errors = 0;
  int ovr_total = 0;
  int vrise_total = 0;
  logic valid_q = 1'b0;

  uart_rx_core #(.OS_RATE(16), .DIV_WIDTH(16)) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .baud_div      (baud_div),
    .parity_mode   (parity_mode),
    .uart_rx       (uart_rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_break      (rx_break),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  // Count overrun pulses and rising edges of rx_valid.
  always @(negedge S_AXI_ACLK) begin
    if (rx_overrun) ovr_total <= ovr_total + 1;
    if (rx_valid && !valid_q) vrise_total <= vrise_total + 1;
    valid_q <= rx_valid;
  end

  typedef struct {
    logic [15:0] div;
    logic [1:0]  mode;
    logic [7:0]  data;
    bit          send_par;
    logic        par_bit;
    logic        stop_bit;
    logic [7:0]  exp_data;
    logic        exp_frame;
    logic        exp_par;
    logic        exp_break;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold one bit on the line for per cycles; optionally invert it briefly
  // around the middle so that exactly one of the three samples is wrong.
  task automatic drive_bit(input logic v, input int per, input bit glitch);
    for (int c = 0; c < per; c++) begin
      @(negedge S_AXI_ACLK);
      if (glitch && (c >= per/2 + 1) && (c <= per/2 + per/16)) uart_rx = ~v;
      else uart_rx = v;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit par_en, input logic par_bit,
                            input logic stop_bit, input int div, input int glitch_bit);
    int per;
    per = 16 * (div + 1);
    drive_bit(1'b0, per, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i], per, (i == glitch_bit));
    if (par_en) drive_bit(par_bit, per, 1'b0);
    drive_bit(stop_bit, per, 1'b0);
    drive_bit(1'b1, 2 * per, 1'b0);
  endtask

  task automatic accept(input string name);
    @(negedge S_AXI_ACLK);
    rx_ready = 1'b1;
    @(negedge S_AXI_ACLK);
    rx_ready = 1'b0;
    chk({name, " valid after accept"}, 32'(rx_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " data"},   32'(rx_data),       32'h0);
    chk({name, " valid"},  32'(rx_valid),      32'h0);
    chk({name, " frame"},  32'(rx_frame_err),  32'h0);
    chk({name, " parity"}, 32'(rx_parity_err), 32'h0);
    chk({name, " break"},  32'(rx_break),      32'h0);
    chk({name, " ovr"},    32'(rx_overrun),    32'h0);
    chk({name, " busy"},   32'(rx_busy),       32'h0);
  endtask

  initial begin
    int o0;
    int v0;

    //            div    mode   data   par   pbit  stop  exp    fr    pe    brk
    vecs[0]  = '{16'd0, 2'b00, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'd3, 2'b01, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'd3, 2'b01, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'd0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{16'd1, 2'b10, 8'h5C, 1'b1, 1'b1, 1'b1, 8'h5C, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'd1, 2'b10, 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{16'd2, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'd0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{16'd0, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{16'd0, 2'b00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{16'd0, 2'b01, 8'h7F, 1'b1, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};

    // Reset with the line held low; release with it still low.
    S_AXI_ARESETN = 1'b0;
    uart_rx       = 1'b0;
    rx_ready      = 1'b0;
    baud_div      = 16'd0;
    parity_mode   = 2'b00;
    repeat (3) @(negedge S_AXI_ACLK);
    chk_all_zero("reset");
    S_AXI_ARESETN = 1'b1;
    repeat (40) @(negedge S_AXI_ACLK);
    chk("low-at-release busy", 32'(rx_busy), 32'd0);
    chk("low-at-release valid", 32'(rx_valid), 32'd0);
    uart_rx = 1'b1;
    repeat (20) @(negedge S_AXI_ACLK);

    // Table of frames.
    for (int i = 0; i < NV; i++) begin
      baud_div    = vecs[i].div;
      parity_mode = vecs[i].mode;
      o0 = ovr_total;
      send_frame(vecs[i].data, vecs[i].send_par, vecs[i].par_bit, vecs[i].stop_bit,
                 int'(vecs[i].div), -1);
      chk($sformatf("v%0d valid", i),  32'(rx_valid),      32'd1);
      chk($sformatf("v%0d data", i),   32'(rx_data),       32'(vecs[i].exp_data));
      chk($sformatf("v%0d frame", i),  32'(rx_frame_err),  32'(vecs[i].exp_frame));
      chk($sformatf("v%0d parity", i), 32'(rx_parity_err), 32'(vecs[i].exp_par));
      chk($sformatf("v%0d break", i),  32'(rx_break),      32'(vecs[i].exp_break));
      chk($sformatf("v%0d busy", i),   32'(rx_busy),       32'd0);
      chk($sformatf("v%0d ovr", i),    32'(ovr_total - o0), 32'd0);
      accept($sformatf("v%0d", i));
    end

    // False start: 5-tick low glitch.
    baud_div = 16'd0;
    parity_mode = 2'b00;
    v0 = vrise_total;
    @(negedge S_AXI_ACLK);
    uart_rx = 1'b0;
    repeat (4) @(negedge S_AXI_ACLK);
    chk("glitch busy", 32'(rx_busy), 32'd1);
    @(negedge S_AXI_ACLK);
    uart_rx = 1'b1;
    repeat (40) @(negedge S_AXI_ACLK);
    chk("glitch busy end", 32'(rx_busy), 32'd0);
    chk("glitch valid", 32'(rx_valid), 32'd0);
    chk("glitch no byte", 32'(vrise_total - v0), 32'd0);

    // One of three samples inverted in data bit 2.
    baud_div = 16'd3;
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 3, 2);
    chk("vote valid", 32'(rx_valid), 32'd1);
    chk("vote data", 32'(rx_data), 32'h96);
    chk("vote frame", 32'(rx_frame_err), 32'd0);
    accept("vote");

    // Overrun: second byte dropped while the first is unaccepted.
    baud_div = 16'd0;
    o0 = ovr_total;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0, -1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0, -1);
    chk("ovr data", 32'(rx_data), 32'h11);
    chk("ovr valid", 32'(rx_valid), 32'd1);
    chk("ovr pulses", 32'(ovr_total - o0), 32'd1);
    accept("ovr");

    // Ready high exactly in the completion cycle of the second byte
    // (stop decision at tick 153, i.e. posedge 157 after the start-bit drive).
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0, -1);
    o0 = ovr_total;
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0, -1);
      begin
        @(negedge S_AXI_ACLK);
        repeat (156) @(negedge S_AXI_ACLK);
        rx_ready = 1'b1;
        @(negedge S_AXI_ACLK);
        rx_ready = 1'b0;
      end
    join
    chk("coincide data", 32'(rx_data), 32'h22);
    chk("coincide valid", 32'(rx_valid), 32'd1);
    chk("coincide ovr", 32'(ovr_total - o0), 32'd0);
    accept("coincide");

    // Reset during data bit 4, then a clean frame.
    v0 = vrise_total;
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 0, -1);
      begin
        @(negedge S_AXI_ACLK);
        repeat (86) @(negedge S_AXI_ACLK);
        chk("pre-reset busy", 32'(rx_busy), 32'd1);
        S_AXI_ARESETN = 1'b0;
        #1;
        chk_all_zero("mid reset");
      end
    join
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    repeat (20) @(negedge S_AXI_ACLK);
    chk("post-reset valid", 32'(rx_valid), 32'd0);
    chk("post-reset busy", 32'(rx_busy), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0, -1);
    chk("after reset data", 32'(rx_data), 32'h5A);
    chk("after reset valid", 32'(rx_valid), 32'd1);
    chk("after reset bytes", 32'(vrise_total - v0), 32'd1);
    accept("after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
